// File: rtl/imem_loader_pkg.sv
// Shared state encoding and constants
// for the instruction-memory loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_HDR_ADDR,
      ST_HDR_LEN,
      ST_DATA,
      ST_CSUM,
      ST_ERR
   } state_t;

   localparam int         LEN_ZERO_MEANS = 256;
   localparam logic [7:0] CSUM_OK        = 8'h00;

endpackage

// File: rtl/imem_loader.sv
// Downloads a framed program (addr, len, data, csum)
// into external instruction memory while holding the CPU.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              load_req,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic [ADDR_W-1:0] cpu_pc,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic              cpu_restart,
   output logic [ADDR_W-1:0] start_addr,
   output logic              load_err
);

   state_t            r_state;
   logic              r_rx_ready;
   logic              r_we;
   logic [DATA_W-1:0] r_wdata;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] r_start;
   logic [8:0]        r_cnt;
   logic [7:0]        r_sum;
   logic              r_hold;
   logic              r_restart;
   logic              r_err;

   logic              w_acc;
   logic [7:0]        w_byte;
   logic [7:0]        w_sum;
   logic [8:0]        w_len;

   assign w_acc  = rx_valid && r_rx_ready;
   assign w_byte = rx_data[7:0];
   assign w_sum  = r_sum + w_byte;
   assign w_len  = (w_byte == 8'h00) ?
                   9'(LEN_ZERO_MEANS) : {1'b0, w_byte};

   // Pointer advances after each write cycle, so it
   // always addresses the byte being written.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_RUN;
         r_rx_ready <= 1'b0;
         r_we       <= 1'b0;
         r_wdata    <= '0;
         r_ptr      <= '0;
         r_base     <= '0;
         r_start    <= '0;
         r_cnt      <= '0;
         r_sum      <= '0;
         r_hold     <= 1'b0;
         r_restart  <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_we      <= 1'b0;
         r_restart <= 1'b0;
         if (r_we) r_ptr <= r_ptr + ADDR_W'(1);
         unique case (r_state)
            ST_RUN, ST_ERR: begin
               if (load_req) begin
                  r_state    <= ST_HDR_ADDR;
                  r_hold     <= 1'b1;
                  r_err      <= 1'b0;
                  r_rx_ready <= 1'b1;
               end
            end
            ST_HDR_ADDR: begin
               if (w_acc) begin
                  r_base  <= ADDR_W'(w_byte);
                  r_ptr   <= ADDR_W'(w_byte);
                  r_sum   <= w_byte;
                  r_state <= ST_HDR_LEN;
               end
            end
            ST_HDR_LEN: begin
               if (w_acc) begin
                  r_cnt   <= w_len;
                  r_sum   <= w_sum;
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_acc) begin
                  r_we    <= 1'b1;
                  r_wdata <= rx_data;
                  r_cnt   <= r_cnt - 9'd1;
                  r_sum   <= w_sum;
                  if (r_cnt == 9'd1) r_state <= ST_CSUM;
               end
            end
            ST_CSUM: begin
               if (w_acc) begin
                  r_rx_ready <= 1'b0;
                  if (w_sum == CSUM_OK) begin
                     r_state   <= ST_RUN;
                     r_hold    <= 1'b0;
                     r_restart <= 1'b1;
                     r_start   <= r_base;
                  end else begin
                     r_state <= ST_ERR;
                     r_err   <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   assign rx_ready    = r_rx_ready;
   assign mem_addr    = (r_state == ST_RUN) ? cpu_pc : r_ptr;
   assign mem_we      = r_we;
   assign mem_wdata   = r_wdata;
   assign cpu_hold    = r_hold;
   assign cpu_restart = r_restart;
   assign start_addr  = r_start;
   assign load_err    = r_err;

endmodule
